// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter gate controller.
// FSM state encoding, width helper and default result width.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 32;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int ceillog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gate_timebase.sv
// Timebase divider: counts 0..TICK_DIV-1 while enabled.
// One-clk tick at terminal count; synchronous clear.
module gate_timebase
  import freq_meter_pkg::*;
#(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = ceillog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_term;

  assign w_term = (r_cnt == LAST);
  assign o_tick = i_en & w_term;

  // Free-running divide while enabled, wrap at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/freq_gate_controller.sv
// Frequency meter sequencer: gate window, edge count, result handshake.
// Optional double buffering via FREQ_CTRL_DBUF_EN (default: off).
module freq_gate_controller
  import freq_meter_pkg::*;
#(
  parameter int TICK_DIV   = 5000,
  parameter int GATE_TICKS = 10000,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             sig_in,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_count,
  output logic             overflow,
  output logic             overrun
);

  localparam int TW = ceillog2(GATE_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(GATE_TICKS - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t r_state;
  state_t w_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_sd;
  logic             w_edge;
  logic             w_arm;
  logic             w_gate;
  logic             w_tick;
  logic             w_last;
  logic             w_take;
  logic             w_sat;
  logic [TW-1:0]    r_ticks;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] r_result;
  logic             r_res_ovf;
  logic             r_valid;

  assign w_edge = r_s2 & ~r_sd;
  assign w_arm  = (r_state == ST_ARM);
  assign w_gate = (r_state == ST_GATE);
  assign w_last = w_gate & w_tick & (r_ticks == TLAST);
  assign w_take = r_valid & meas_ready;
  assign w_sat  = (r_cnt == CMAX);

  // Saturating count; overflow marks an edge lost at full scale.
  assign w_cnt_nxt = (w_edge & ~w_sat) ? r_cnt + 1'b1 : r_cnt;
  assign w_ovf_nxt = r_ovf | (w_edge & w_sat);

  gate_timebase #(
    .TICK_DIV (TICK_DIV)
  ) u_tb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_arm),
    .i_en   (w_gate),
    .o_tick (w_tick)
  );

  // Two-flop synchronizer plus delay flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sd <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_sd <= r_s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start | continuous) w_next = ST_ARM;
      ST_ARM:  w_next = ST_GATE;
      ST_GATE: begin
        if (w_last) begin
`ifdef FREQ_CTRL_DBUF_EN
          w_next = continuous ? ST_ARM : ST_HOLD;
`else
          w_next = ST_HOLD;
`endif
        end
      end
      ST_HOLD: begin
        if (w_take) w_next = continuous ? ST_ARM : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // Tick and edge counters: cleared in ARM, live only in GATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ticks <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_arm) begin
      r_ticks <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_gate) begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_tick) r_ticks <= r_ticks + 1'b1;
    end
  end

  // Result buffer; a new result wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_res_ovf <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_last) begin
      r_result  <= w_cnt_nxt;
      r_res_ovf <= w_ovf_nxt;
      r_valid   <= 1'b1;
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  assign meas_valid = r_valid;
  assign meas_count = r_result;
  assign overflow   = r_res_ovf;

`ifdef FREQ_CTRL_DBUF_EN
  logic r_ovr;

  // Sticky flag: an unread result was replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovr <= 1'b0;
    else if (w_last & r_valid & ~meas_ready) r_ovr <= 1'b1;
  end

  assign overrun = r_ovr;
`else
  assign overrun = 1'b0;
`endif

endmodule
